spi_master: RTL and testbench

- SPI mode-0 master, MSB first. Drives sck/ss/mosi and samples miso; one 8-bit full-duplex exchange per start request.
- Pairs with the existing spi slave block: its dout arrives here on miso, and our din is what the slave sees on mosi.
- Sits between a local controller (start/busy/done handshake) and the off-chip or on-chip SPI slave.

---
 rtl/spi_master.sv | 160 ++++++++++++++++
 tb/tb_spi_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master, MSB first, one 8-bit full-duplex exchange
// per accepted start. sck idles low, ss idles high.
// Optional build macro SPI_MASTER_SS_HOLD_EN adds a 'hold' input that keeps
// ss asserted across consecutive bytes to form multi-byte frames.
module spi_master #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       ss,
  output logic       mosi,
`ifdef SPI_MASTER_SS_HOLD_EN
  input  logic       hold,
`endif
  input  logic       miso
);

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("spi_master: CLK_DIV must be >= 2");
    end
  endgenerate

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TAIL, DONE} state_t;

  state_t        state;
  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic          div_last;
`ifdef SPI_MASTER_SS_HOLD_EN
  logic          chain;
`endif

  // Reset asserts immediately, releases two clk edges after rst goes high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign div_last = (div_cnt == DIV_LAST);
  // MSB of the transmit shifter is the mosi flop; it is zeroed at frame end
  assign mosi     = tx_sr[7];

  // Transfer sequencer: phase timing, shifting, handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      dout    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sck     <= 1'b0;
      ss      <= 1'b1;
`ifdef SPI_MASTER_SS_HOLD_EN
      chain   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (start) begin
            tx_sr <= din;
            busy  <= 1'b1;
            ss    <= 1'b0;
`ifdef SPI_MASTER_SS_HOLD_EN
            // ss is already low on a chained byte, so no setup gap is needed
            state <= chain ? LOW : SETUP;
`else
            state <= SETUP;
`endif
          end
`ifdef SPI_MASTER_SS_HOLD_EN
          else begin
            // An idle cycle without start breaks the frame
            ss    <= 1'b1;
            chain <= 1'b0;
          end
`endif
        end
        SETUP: begin
          if (div_last) begin
            div_cnt <= '0;
            sck     <= 1'b1;
            rx_sr   <= {rx_sr[6:0], miso};
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (div_last) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            if (bit_cnt != 3'd7) begin
              tx_sr   <= {tx_sr[6:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
              state   <= LOW;
            end else begin
              state   <= TAIL;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LOW: begin
          if (div_last) begin
            div_cnt <= '0;
            sck     <= 1'b1;
            rx_sr   <= {rx_sr[6:0], miso};
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        TAIL: begin
          if (div_last) begin
            div_cnt <= '0;
            tx_sr   <= '0;
            dout    <= rx_sr;
            done    <= 1'b1;
            state   <= DONE;
`ifdef SPI_MASTER_SS_HOLD_EN
            ss      <= ~hold;
            chain   <= hold;
`else
            ss      <= 1'b1;
`endif
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: table-driven exchanges against a mode-0 slave model, with a
// scoreboard of expected (dout, slave-received) pairs popped on each done.
module tb_spi_master;

  localparam int D   = 4;
  localparam int LAT = 17 * D + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       busy, done, sck, ss, mosi;
  logic       miso = 1'b0;
`ifdef SPI_MASTER_SS_HOLD_EN
  logic       hold = 1'b0;
`endif

  spi_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .dout(dout),
    .busy(busy), .done(done), .sck(sck), .ss(ss), .mosi(mosi),
`ifdef SPI_MASTER_SS_HOLD_EN
    .hold(hold),
`endif
    .miso(miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Slave model: loads preload on ss fall, shifts out after each sck fall,
  // captures mosi on sck rise, reloads after every 8 bits for chained frames
  logic [7:0] s_pre = 8'h00, s_sr = 8'h00, s_rx = 8'h00;
  int         s_bits = 0;
  always @(negedge ss) begin
    s_sr   = s_pre;
    s_bits = 0;
    miso   = s_sr[7];
  end
  always @(posedge sck) begin
    s_rx = {s_rx[6:0], mosi};
    s_bits++;
  end
  always @(negedge sck) begin
    s_sr = {s_sr[6:0], 1'b0};
    if (s_bits % 8 == 0) s_sr = s_pre;
    miso = s_sr[7];
  end

  typedef struct {
    logic [7:0] dout;
    logic [7:0] srx;
  } exp_t;
  exp_t sb_q[$];

  // Monitor: edge counts, phase timing, scoreboard pop on done
  int   n_rise = 0, n_fall = 0, n_done = 0, n_ssrise = 0, terr = 0;
  int   t_ssf = 0, t_rise = 0, t_fall = 0;
  bit   first = 1'b0, mon_en = 1'b1;
  logic psck = 1'b0, pss = 1'b1, pmosi = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (!ss && pss) begin t_ssf = cyc; first = 1'b1; end
      if (sck && !psck) begin
        n_rise++;
        if (mon_en) begin
          if (first) begin if (cyc - t_ssf != D) terr++; end
          else if (cyc - t_fall != D) terr++;
        end
        first  = 1'b0;
        t_rise = cyc;
      end
      if (!sck && psck) begin
        n_fall++;
        if (mon_en && cyc - t_rise != D) terr++;
        t_fall = cyc;
      end
      if (ss && !pss) begin
        n_ssrise++;
        if (mon_en && cyc - t_fall != D) terr++;
      end
      if (mon_en && mosi !== pmosi && sck) terr++;
      if (done === 1'b1) begin
        exp_t e;
        n_done++;
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: done=1 with no transfer outstanding at cycle %0d", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("sb_dout", dout, e.dout);
          chk("sb_slave_rx", s_rx, e.srx);
        end
      end
    end
    psck = sck; pss = ss; pmosi = mosi;
  end

  int t_acc;

  task automatic kick(input logic [7:0] pre, input logic [7:0] d);
    exp_t e;
    s_pre = pre;
    @(negedge clk);
    din   = d;
    start = 1'b1;
    t_acc = cyc;
    e.dout = pre;
    e.srx  = d;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    din   = ~d;
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin t = cyc; break; end
    end
    if (t < 0) begin
      n_chk++;
      $display("FAIL done_timeout: no done within 400 cycles");
    end
  endtask

  task automatic wait_bits(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (s_bits >= n) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL bit_timeout: slave saw %0d bits, wanted %0d", s_bits, n);
    end
  endtask

  typedef struct {
    logic [7:0] pre;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic [7:0] exp_srx;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int t, r0, f0, d0, e0, s0;
    vecs[0] = '{8'h3C, 8'hA5, 8'h3C, 8'hA5};
    vecs[1] = '{8'h00, 8'hAA, 8'h00, 8'hAA};
    vecs[2] = '{8'hAA, 8'hFF, 8'hAA, 8'hFF};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[4] = '{8'hBE, 8'hAA, 8'hBE, 8'hAA};

    // Reset state
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sck", sck, 1'b0);
    chk("rst_ss", ss, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dout", dout, 8'h00);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven exchanges
    for (int i = 0; i < 5; i++) begin
      r0 = n_rise; f0 = n_fall; d0 = n_done; e0 = terr;
      kick(vecs[i].pre, vecs[i].din);
      sb_q[sb_q.size()-1].dout = vecs[i].exp_dout;
      sb_q[sb_q.size()-1].srx  = vecs[i].exp_srx;
      wait_done(t);
      chk("latency", t - t_acc, LAT);
      chk("busy_at_done", busy, 1'b1);
      @(negedge clk);
      chk("done_pulse_width", done, 1'b0);
      chk("busy_after", busy, 1'b0);
      chk("sck_rises", n_rise - r0, 8);
      chk("sck_falls", n_fall - f0, 8);
      chk("done_count", n_done - d0, 1);
      chk("timing_errs", terr - e0, 0);
      repeat (3) @(negedge clk);
    end

    // Start pulsed during bit 2 of a transfer is ignored
    r0 = n_rise; d0 = n_done; e0 = terr;
    kick(8'h5C, 8'hAA);
    wait_bits(2);
    din = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(t);
    chk("busy_latency", t - t_acc, LAT);
    repeat (80) @(negedge clk);
    chk("busy_done_count", n_done - d0, 1);
    chk("busy_sck_rises", n_rise - r0, 8);
    chk("busy_ss_idle", ss, 1'b1);
    chk("busy_dout", dout, 8'h5C);
    chk("busy_timing_errs", terr - e0, 0);

    // Reset in the middle of bit 3
    mon_en = 1'b0;
    d0 = n_done;
    kick(8'h77, 8'h11);
    wait_bits(3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_sck", sck, 1'b0);
    chk("midrst_ss", ss, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_dout", dout, 8'h00);
    chk("midrst_no_done", n_done - d0, 0);

`ifdef SPI_MASTER_SS_HOLD_EN
    // Two-byte frame with ss held low between bytes
    begin
      exp_t e;
      r0 = n_rise; d0 = n_done; s0 = n_ssrise;
      hold = 1'b1;
      s_pre = 8'h5A;
      @(negedge clk);
      din = 8'h12; start = 1'b1;
      e.dout = 8'h5A; e.srx = 8'h12; sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      s_pre = 8'hC3;
      e.dout = 8'hC3; e.srx = 8'h34; sb_q.push_back(e);
      wait_done(t);
      chk("hold_ss_low_done1", ss, 1'b0);
      din = 8'h34; start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      hold  = 1'b0;
      wait_done(t);
      chk("hold_ss_high_done2", ss, 1'b1);
      @(negedge clk);
      chk("hold_sck_rises", n_rise - r0, 16);
      chk("hold_done_count", n_done - d0, 2);
      chk("hold_ss_rises", n_ssrise - s0, 1);
      chk("hold_dout", dout, 8'hC3);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
